// File: rtl/mrv1_wb_arb.sv
// mrv1_wb_arb -- writeback arbiter for the single write port of the
// multithreaded register file.
//
// ALU results arrive unbuffered and are held by the producer until granted.
// LSU load results are queued in a small FIFO. At most one result is granted
// per cycle. The granted result is registered onto the rd_* outputs one cycle
// later, together with a wb_done_o pulse used for scoreboard release. Results
// to x0 retire (wb_done_o=1) but never assert rd_w_en_o.
//
// Optional feature: define MRV1_WB_FWD_EN to add the write-port forwarding
// compare outputs (rs0_fwd_o / rs1_fwd_o / fwd_data_o).
//
// Ports
//   clk_i                      clock
//   rst_i                      synchronous reset, active low
//   alu_valid_i/ready_o        ALU handshake (ready = granted this cycle)
//   alu_twid_i/rd_addr_i/data_i ALU result, thread id, destination
//   lsu_valid_i/ready_o        LSU handshake (ready = FIFO not full)
//   lsu_twid_i/rd_addr_i/data_i LSU load result, thread id, destination
//   rd_w_en_o                  RF write enable (registered)
//   rd_twid_o/addr_o/data_o    RF write thread id, address, data
//   wb_done_o                  result retired this cycle (includes x0)
//   rs_twid_i, rs0/rs1_addr_i  [MRV1_WB_FWD_EN] operand read thread/addresses
//   rs0/rs1_fwd_o, fwd_data_o  [MRV1_WB_FWD_EN] forwarding hit flags and data
module mrv1_wb_arb #(
    parameter int DATA_WIDTH_P     = 32,
    parameter int NUM_TW_P         = 8,
    parameter int rf_addr_width_p  = 5,
    parameter int LSU_FIFO_DEPTH_P = 4,
    localparam int twid_width_lp   = $clog2(NUM_TW_P)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [twid_width_lp-1:0]   alu_twid_i,
    input  logic [rf_addr_width_p-1:0] alu_rd_addr_i,
    input  logic [DATA_WIDTH_P-1:0]    alu_data_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [twid_width_lp-1:0]   lsu_twid_i,
    input  logic [rf_addr_width_p-1:0] lsu_rd_addr_i,
    input  logic [DATA_WIDTH_P-1:0]    lsu_data_i,
`ifdef MRV1_WB_FWD_EN
    input  logic [twid_width_lp-1:0]   rs_twid_i,
    input  logic [rf_addr_width_p-1:0] rs0_addr_i,
    input  logic [rf_addr_width_p-1:0] rs1_addr_i,
    output logic                       rs0_fwd_o,
    output logic                       rs1_fwd_o,
    output logic [DATA_WIDTH_P-1:0]    fwd_data_o,
`endif
    output logic                       rd_w_en_o,
    output logic [twid_width_lp-1:0]   rd_twid_o,
    output logic [rf_addr_width_p-1:0] rd_addr_o,
    output logic [DATA_WIDTH_P-1:0]    rd_data_o,
    output logic                       wb_done_o
);

    localparam int ptr_w_lp = $clog2(LSU_FIFO_DEPTH_P);
    localparam int cnt_w_lp = $clog2(LSU_FIFO_DEPTH_P + 1);
    localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(LSU_FIFO_DEPTH_P);

    logic [twid_width_lp-1:0]   fifo_twid_q [LSU_FIFO_DEPTH_P];
    logic [rf_addr_width_p-1:0] fifo_addr_q [LSU_FIFO_DEPTH_P];
    logic [DATA_WIDTH_P-1:0]    fifo_data_q [LSU_FIFO_DEPTH_P];

    logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0] count_q;
    logic                rr_q;   // 0: ALU wins the next tie, 1: LSU wins

    logic lsu_req, fifo_full, tie;
    logic alu_gnt, lsu_gnt, any_gnt;
    logic push, pop;

    logic [twid_width_lp-1:0]   sel_twid;
    logic [rf_addr_width_p-1:0] sel_addr;
    logic [DATA_WIDTH_P-1:0]    sel_data;

    logic                       rd_w_en_q, wb_done_q;
    logic [twid_width_lp-1:0]   rd_twid_q;
    logic [rf_addr_width_p-1:0] rd_addr_q;
    logic [DATA_WIDTH_P-1:0]    rd_data_q;

    // Grant: a full FIFO always beats the ALU so loads never stall the LSU;
    // otherwise ties alternate.
    always_comb begin
        lsu_req   = (count_q != '0);
        fifo_full = (count_q == depth_lp);
        tie       = alu_valid_i & lsu_req;
        alu_gnt   = alu_valid_i & (~lsu_req | (~fifo_full & ~rr_q));
        lsu_gnt   = lsu_req & ~alu_gnt;
        any_gnt   = alu_gnt | lsu_gnt;
        push      = lsu_valid_i & ~fifo_full;
        pop       = lsu_gnt;

        sel_twid = alu_twid_i;
        sel_addr = alu_rd_addr_i;
        sel_data = alu_data_i;
        if (lsu_gnt) begin
            sel_twid = fifo_twid_q[rd_ptr_q];
            sel_addr = fifo_addr_q[rd_ptr_q];
            sel_data = fifo_data_q[rd_ptr_q];
        end
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = ~fifo_full;

    // FIFO storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_twid_q[wr_ptr_q] <= lsu_twid_i;
            fifo_addr_q[wr_ptr_q] <= lsu_rd_addr_i;
            fifo_data_q[wr_ptr_q] <= lsu_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + cnt_w_lp'(1);
                2'b01:   count_q <= count_q - cnt_w_lp'(1);
                default: count_q <= count_q;
            endcase
            if (tie) rr_q <= alu_gnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_w_en_q <= 1'b0;
            wb_done_q <= 1'b0;
            rd_twid_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            wb_done_q <= any_gnt;
            rd_w_en_q <= any_gnt & (sel_addr != '0);
            if (any_gnt) begin
                rd_twid_q <= sel_twid;
                rd_addr_q <= sel_addr;
                rd_data_q <= sel_data;
            end
        end
    end

    assign rd_w_en_o = rd_w_en_q;
    assign wb_done_o = wb_done_q;
    assign rd_twid_o = rd_twid_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

`ifdef MRV1_WB_FWD_EN
    assign rs0_fwd_o  = rd_w_en_q & (rd_twid_q == rs_twid_i) & (rd_addr_q == rs0_addr_i);
    assign rs1_fwd_o  = rd_w_en_q & (rd_twid_q == rs_twid_i) & (rd_addr_q == rs1_addr_i);
    assign fwd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_mrv1_wb_arb.sv
module tb_mrv1_wb_arb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          alu_valid_i = 1'b0;
    logic          alu_ready_o;
    logic [TW-1:0] alu_twid_i = '0;
    logic [AW-1:0] alu_rd_addr_i = '0;
    logic [DW-1:0] alu_data_i = '0;
    logic          lsu_valid_i = 1'b0;
    logic          lsu_ready_o;
    logic [TW-1:0] lsu_twid_i = '0;
    logic [AW-1:0] lsu_rd_addr_i = '0;
    logic [DW-1:0] lsu_data_i = '0;
    logic          rd_w_en_o;
    logic [TW-1:0] rd_twid_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_o;
    logic          wb_done_o;
`ifdef MRV1_WB_FWD_EN
    logic [TW-1:0] rs_twid_i = '0;
    logic [AW-1:0] rs0_addr_i = '0;
    logic [AW-1:0] rs1_addr_i = '0;
    logic          rs0_fwd_o;
    logic          rs1_fwd_o;
    logic [DW-1:0] fwd_data_o;
`endif

    mrv1_wb_arb dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_twid_i    (alu_twid_i),
        .alu_rd_addr_i (alu_rd_addr_i),
        .alu_data_i    (alu_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_twid_i    (lsu_twid_i),
        .lsu_rd_addr_i (lsu_rd_addr_i),
        .lsu_data_i    (lsu_data_i),
`ifdef MRV1_WB_FWD_EN
        .rs_twid_i     (rs_twid_i),
        .rs0_addr_i    (rs0_addr_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs0_fwd_o     (rs0_fwd_o),
        .rs1_fwd_o     (rs1_fwd_o),
        .fwd_data_o    (fwd_data_o),
`endif
        .rd_w_en_o     (rd_w_en_o),
        .rd_twid_o     (rd_twid_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .wb_done_o     (wb_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          wen;
        logic [TW-1:0] twid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t sb_q[$];     // expected RF writes, in grant order
    wb_t lsu_q[$];    // LSU results accepted into the DUT FIFO, in order
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every retired writeback must match the head of the scoreboard.
    always @(negedge clk_i) begin
        wb_t e;
        if (wb_done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wb: got twid %0d addr %0d data 0x%0h, expected no writeback (t=%0t)",
                         rd_twid_o, rd_addr_o, rd_data_o, $time);
            end else begin
                e = sb_q.pop_front();
                chk("wb_w_en", 32'(rd_w_en_o), 32'(e.wen));
                chk("wb_twid", 32'(rd_twid_o), 32'(e.twid));
                chk("wb_addr", 32'(rd_addr_o), 32'(e.addr));
                chk("wb_data", rd_data_o, e.data);
            end
        end
    end

    // One clock cycle: drive inputs, check the combinational handshakes
    // against the hand-computed grant (0 none, 1 ALU, 2 LSU), and record
    // the expected writeback for the grant taken at the coming edge.
    task automatic cyc(input logic av, input logic [TW-1:0] at, input logic [AW-1:0] ar,
                       input logic [DW-1:0] ad, input logic lv, input logic [TW-1:0] lt,
                       input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                       input int gnt, input logic exp_lrdy, input string tag);
        wb_t e;
        @(posedge clk_i);
        #1;
        alu_valid_i = av; alu_twid_i = at; alu_rd_addr_i = ar; alu_data_i = ad;
        lsu_valid_i = lv; lsu_twid_i = lt; lsu_rd_addr_i = lr; lsu_data_i = ld;
        #1;
        chk({tag, "_alu_ready"}, 32'(alu_ready_o), 32'(gnt == 1));
        chk({tag, "_lsu_ready"}, 32'(lsu_ready_o), 32'(exp_lrdy));
        if (gnt == 1) begin
            sb_q.push_back({ar != '0, at, ar, ad});
        end else if (gnt == 2 && lsu_q.size() != 0) begin
            e = lsu_q.pop_front();
            sb_q.push_back(e);
        end
        if (lv && exp_lrdy) lsu_q.push_back({lr != '0, lt, lr, ld});
    endtask

    task automatic idle(input int gnt, input logic exp_lrdy, input string tag);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, gnt, exp_lrdy, tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_w_en"},      32'(rd_w_en_o), 32'd0);
        chk({tag, "_done"},      32'(wb_done_o), 32'd0);
        chk({tag, "_data"},      rd_data_o, 32'd0);
        chk({tag, "_addr"},      32'(rd_addr_o), 32'd0);
        chk({tag, "_lsu_ready"}, 32'(lsu_ready_o), 32'd1);
        chk({tag, "_alu_ready"}, 32'(alu_ready_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1 check_reset_state("rst");

        // 1: ALU only
        cyc(1, 3, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, "t1");
        idle(0, 1, "t1_c1");

        // 2: LSU only, two-cycle latency
        cyc(0, 0, 0, 0, 1, 1, 7, 32'h12345678, 0, 1, "t2_push");
        idle(2, 1, "t2_c1");
        chk("t2_c1_w_en", 32'(rd_w_en_o), 32'd0);
        idle(0, 1, "t2_c2");

        // 3: contention, round robin; first tie goes to the ALU
        cyc(1, 0, 1, 32'h100, 1, 2, 2, 32'h200, 1, 1, "t3_0");
        cyc(1, 1, 3, 32'h101, 1, 3, 4, 32'h201, 1, 1, "t3_1");
        cyc(1, 4, 6, 32'h102, 0, 0, 0, 0,       2, 1, "t3_2");
        cyc(1, 4, 6, 32'h102, 0, 0, 0, 0,       1, 1, "t3_3");
        cyc(1, 5, 8, 32'h103, 0, 0, 0, 0,       2, 1, "t3_4");
        cyc(1, 5, 8, 32'h103, 0, 0, 0, 0,       1, 1, "t3_5");

        // 4: fill the FIFO while the ALU saturates the port
        cyc(1, 6, 10, 32'h300, 1, 0, 11, 32'h400, 1, 1, "t4_0");
        cyc(1, 7, 12, 32'h301, 1, 1, 13, 32'h401, 1, 1, "t4_1");
        cyc(1, 0, 14, 32'h302, 1, 2, 15, 32'h402, 2, 1, "t4_2");
        cyc(1, 0, 14, 32'h302, 1, 3, 16, 32'h403, 1, 1, "t4_3");
        cyc(1, 4, 17, 32'h303, 1, 4, 18, 32'h404, 2, 1, "t4_4");
        cyc(1, 4, 17, 32'h303, 1, 5, 19, 32'h405, 1, 1, "t4_5");
        cyc(1, 1, 20, 32'h304, 1, 6, 21, 32'h406, 2, 0, "t4_full");
        cyc(1, 1, 20, 32'h304, 1, 6, 21, 32'h406, 1, 1, "t4_after_pop");
        idle(2, 0, "t4_drain0");
        idle(2, 1, "t4_drain1");
        idle(2, 1, "t4_drain2");
        idle(2, 1, "t4_drain3");
        idle(0, 1, "t4_empty");

        // 5: x0 write retires without a write enable
        cyc(1, 4, 0, 32'h55, 0, 0, 0, 0, 1, 1, "t5_x0");
        // leave three entries in the FIFO, then reset
        cyc(1, 2, 1, 32'h500, 1, 3, 2, 32'h600, 1, 1, "t5_f0");
        cyc(1, 2, 3, 32'h501, 1, 3, 4, 32'h601, 2, 1, "t5_f1");
        cyc(1, 2, 3, 32'h501, 1, 3, 5, 32'h602, 1, 1, "t5_f2");
        cyc(1, 2, 6, 32'h502, 1, 3, 7, 32'h603, 2, 1, "t5_f3");
        cyc(1, 2, 6, 32'h502, 1, 3, 8, 32'h604, 1, 1, "t5_f4");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        lsu_q.delete();
        #1 check_reset_state("t5_rst");
        idle(0, 1, "t5_post0");
        idle(0, 1, "t5_post1");
        // arbitration pointer must be back to "ALU wins next tie"
        cyc(0, 0, 0, 0, 1, 1, 9, 32'h700, 0, 1, "t5_w0");
        cyc(1, 0, 10, 32'h800, 0, 0, 0, 0, 1, 1, "t5_w1");
        idle(2, 1, "t5_w2");
        idle(0, 1, "t5_w3");

`ifdef MRV1_WB_FWD_EN
        // 6: forwarding compare on the registered write port
        cyc(1, 2, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 1, "t6_a");
        idle(0, 1, "t6_a1");
        rs_twid_i = 2; rs0_addr_i = 9; rs1_addr_i = 4;
        #1;
        chk("t6_rs0_fwd", 32'(rs0_fwd_o), 32'd1);
        chk("t6_rs1_fwd", 32'(rs1_fwd_o), 32'd0);
        chk("t6_fwd_data", fwd_data_o, 32'hA5A5A5A5);
        cyc(1, 2, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 1, "t6_b");
        idle(0, 1, "t6_b1");
        rs_twid_i = 3;
        #1;
        chk("t6_rs0_fwd_other", 32'(rs0_fwd_o), 32'd0);
        chk("t6_rs1_fwd_other", 32'(rs1_fwd_o), 32'd0);
`endif

        idle(0, 1, "end0");
        idle(0, 1, "end1");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
